// File: rtl/jpeg_blk_sched_pkg.sv
// rtl/jpeg_blk_sched_pkg.sv - shared encodings and defaults for the JPEG block scheduler
package jpeg_blk_sched_pkg;

  localparam int SLOTS_DEFAULT = 4;
  localparam int BEATS_DEFAULT = 64;

  // Per-slot state in the coefficient buffer; a slot being filled is FREE
  localparam logic [1:0] SLOT_FREE     = 2'd0;
  localparam logic [1:0] SLOT_READY    = 2'd1;
  localparam logic [1:0] SLOT_DRAINING = 2'd2;

  // Read sequencer states
  localparam logic [1:0] SEQ_IDLE   = 2'd0;
  localparam logic [1:0] SEQ_SETUP  = 2'd1;
  localparam logic [1:0] SEQ_ACTIVE = 2'd2;

endpackage

// File: rtl/jpeg_blk_seq.sv
// rtl/jpeg_blk_seq.sv - read FSM and beat counter for one block drain
module jpeg_blk_seq
  import jpeg_blk_sched_pkg::*;
#(
  parameter int BEATS = BEATS_DEFAULT
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     slot_ready_i,
  input  logic                     accept_i,
  output logic                     start_o,
  output logic                     done_o,
  output logic                     setup_o,
  output logic                     valid_o,
  output logic                     last_o,
  output logic [$clog2(BEATS)-1:0] idx_o
);

  localparam int IW = $clog2(BEATS);
  localparam logic [IW-1:0] LAST_IDX = IW'(BEATS - 1);

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;

  // Next-state: IDLE waits for a READY slot, SETUP lasts one cycle, ACTIVE walks the beats
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    start_o = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        if (slot_ready_i) begin
          state_d = SEQ_SETUP;
          idx_d   = '0;
          start_o = 1'b1;
        end
      end
      SEQ_SETUP: state_d = SEQ_ACTIVE;
      SEQ_ACTIVE: begin
        if (accept_i) begin
          if (idx_q == LAST_IDX) begin
            state_d = SEQ_IDLE;
            idx_d   = '0;
            done_o  = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
    if (clear_i) begin
      state_d = SEQ_IDLE;
      idx_d   = '0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= SEQ_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign setup_o = (state_q == SEQ_SETUP);
  assign valid_o = (state_q == SEQ_ACTIVE);
  assign last_o  = valid_o && (idx_q == LAST_IDX);
  assign idx_o   = idx_q;

endmodule

// File: rtl/jpeg_blk_sched.sv
// rtl/jpeg_blk_sched.sv - coefficient buffer slot scheduler between block writer and reader
module jpeg_blk_sched
  import jpeg_blk_sched_pkg::*;
#(
  parameter int SLOTS = SLOTS_DEFAULT,
  parameter int BEATS = BEATS_DEFAULT
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     img_start_i,
  input  logic                     wr_eob_i,
  output logic                     wr_ready_o,
  output logic [$clog2(SLOTS)-1:0] wr_slot_o,
  input  logic                     rd_accept_i,
  output logic                     rd_valid_o,
  output logic [$clog2(SLOTS)-1:0] rd_slot_o,
  output logic [$clog2(BEATS)-1:0] rd_idx_o,
  output logic                     rd_last_o,
  output logic                     rd_setup_o,
  output logic [$clog2(SLOTS):0]   occupancy_o,
  output logic [15:0]              blk_count_o
);

  localparam int SW = $clog2(SLOTS);

  logic [SLOTS-1:0][1:0] slot_q, slot_d;
  logic [SW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [SW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [SW:0]           occ_q, occ_d;
  logic [15:0]           blk_q, blk_d;

  logic wr_fire;
  logic seq_start;
  logic seq_done;

  assign wr_ready_o = (slot_q[wr_ptr_q] == SLOT_FREE);
  assign wr_fire    = wr_eob_i && wr_ready_o;

  jpeg_blk_seq #(
    .BEATS(BEATS)
  ) u_seq (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (img_start_i),
    .slot_ready_i(slot_q[rd_ptr_q] == SLOT_READY),
    .accept_i    (rd_accept_i),
    .start_o     (seq_start),
    .done_o      (seq_done),
    .setup_o     (rd_setup_o),
    .valid_o     (rd_valid_o),
    .last_o      (rd_last_o),
    .idx_o       (rd_idx_o)
  );

  // Slot bookkeeping; write and read touch different slots since one needs FREE and the other READY/DRAINING
  always_comb begin
    slot_d   = slot_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    blk_d    = blk_q;
    if (wr_fire) begin
      slot_d[wr_ptr_q] = SLOT_READY;
      wr_ptr_d         = wr_ptr_q + SW'(1);
    end
    if (seq_start) begin
      slot_d[rd_ptr_q] = SLOT_DRAINING;
    end
    if (seq_done) begin
      slot_d[rd_ptr_q] = SLOT_FREE;
      rd_ptr_d         = rd_ptr_q + SW'(1);
      blk_d            = blk_q + 16'd1;
    end
    case ({wr_fire, seq_done})
      2'b10:   occ_d = occ_q + (SW + 1)'(1);
      2'b01:   occ_d = occ_q - (SW + 1)'(1);
      default: occ_d = occ_q;
    endcase
    if (img_start_i) begin
      slot_d   = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      blk_d    = '0;
    end
  end

  // Bookkeeping registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      slot_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      blk_q    <= '0;
    end else begin
      slot_q   <= slot_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      blk_q    <= blk_d;
    end
  end

  assign wr_slot_o   = wr_ptr_q;
  assign rd_slot_o   = rd_ptr_q;
  assign occupancy_o = occ_q;
  assign blk_count_o = blk_q;

endmodule
